alu_div_seq: RTL and testbench
==============================

Name: alu_div_seq

Overview:
- Iterative restoring divider; the inverse of the ALU's combinational multiply. Serves MIPS div/divu.
- Produces one quotient bit per clock, then applies a one-cycle sign fix-up.
- Uses a start/busy/done handshake toward the datapath control. Results are held until the next accepted start, for the HI/LO writeback.

Parameters:
- data_width, 32, operand, quotient and remainder width; must be ≥2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- signed_op  in  1  1 = two's-complement div, 0 = divu
- dividend  in  data_width  numerator
- divisor  in  data_width  denominator
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse when results become valid
- quotient  out  data_width  registered quotient
- remainder  out  data_width  registered remainder
- div_by_zero  out  1  registered flag for the last operation

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- State IDLE:
  - On an edge with start=1: capture signed_op, sign bits and operand magnitudes. Magnitude is the negated value when signed_op=1 and MSB=1; otherwise the raw value.
  - 0x80000000 has magnitude 2^31, which fits unsigned.
  - Clear the partial remainder (data_width+1 bits) and counter. busy←1, div_by_zero←0. Go to CALC.
- State CALC, one step per edge:
  - Shift {prem, dvd} left by 1.
  - Trial = prem − divisor magnitude.
  - If trial ≥ 0: prem←trial, new quotient bit=1. Else the quotient bit is 0.
  - After data_width steps (counter = data_width−1), go to FIX.
- State FIX, one edge:
  - Quotient is negated iff signed_op and the operand signs differ.
  - Remainder takes the dividend's sign.
  - Write quotient/remainder, done←1, busy←0, state←IDLE.
- Latency: capture edge E0, iterations E1..E(data_width), FIX at E(data_width+1). done is high for the cycle after E(data_width+1), i.e. 33 edges after capture at default width.
- done is high exactly one cycle. Outputs hold their values until the next FIX writes.
- Back-to-back: a start in the cycle where done=1 is accepted, since state is already IDLE. busy rises on that edge.
- start while busy=1: ignored; in-flight operands are unaffected.
- Divide by zero (divisor==0), overriding FIX: quotient=all ones, remainder=raw dividend, div_by_zero=1. This holds for both signed_op values. Latency is unchanged without the optional feature.
- Signed overflow, 0x80000000 / 0xFFFFFFFF (signed): quotient=0x80000000 (wrap), remainder=0. No flag.
- Reset mid-operation: rst forces the reset values immediately, without waiting for clk. The in-flight operation is lost and no done pulse occurs.
- Operand inputs are don't-care except on the capture edge.

Optional Feature:
- Macro: ALU_DIV_ZERO_FAST_EN.
- Defined: divisor==0 at capture skips CALC and goes directly to FIX with the divide-by-zero result. done is high in the cycle after E1; busy is high for one cycle only.
- Undefined: divide by zero runs the full data_width+1 edge sequence. Results are identical; only latency differs.

Decomposition:
- Package alu_div_pkg:
  - state enum {IDLE, CALC, FIX}
  - default data_width constant
  - counter width constant = $clog2(data_width)
  - DIV_ZERO_QUOTIENT constant (all ones)
- One natural sub-module, div_step: combinational restoring step.
  - Inputs: prem, next dividend bit, divisor magnitude.
  - Outputs: new prem, quotient bit.
  - Reusable if a later radix-4 version unrolls two steps.

Test Plan:
- Unsigned basic: signed_op=0, 100/7 → quotient=14, remainder=2, div_by_zero=0. done exactly 33 edges after capture; busy high 33 cycles.
- Signed mixed signs:
  - −7/2 (0xFFFFFFF9/0x00000002) → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - 7/−2 → quotient=0xFFFFFFFD, remainder=0x00000001.
- Signed overflow and full-range unsigned:
  - 0x80000000/0xFFFFFFFF signed → quotient=0x80000000, remainder=0.
  - Same operands unsigned → quotient=0, remainder=0x80000000.
- Divide by zero: 0x12345678/0 → quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1. done after 33 edges without ALU_DIV_ZERO_FAST_EN, after 1 edge with it. The next start clears div_by_zero.
- Handshake:
  - start pulsed mid-CALC with other operands → ignored; the original result is delivered.
  - start asserted during the done cycle → accepted, with busy high on the next cycle.
- Reset mid-CALC: assert rst between clock edges at iteration 10 → all outputs 0 immediately, no done pulse. A subsequent 50/5 returns quotient=10, remainder=0.

Source files
------------

// File: rtl/alu_div_pkg.sv
// Shared types and constants for the sequential restoring divider (MIPS div/divu).
package alu_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned CNT_W      = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/alu_div_seq_div_step.sv
// One combinational restoring-division step: shift in one dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned data_width = 32
) (
  input  logic [data_width:0]   prem,
  input  logic                  dvd_bit,
  input  logic [data_width-1:0] dsr,
  output logic [data_width:0]   prem_next,
  output logic                  q_bit
);

  logic [data_width:0]   w_shift;
  logic [data_width+1:0] w_trial;
  // prem is always below the divisor magnitude, so its MSB is zero on entry
  logic                  w_unused_msb;

  always_comb begin
    w_unused_msb = prem[data_width];
    w_shift      = {prem[data_width-1:0], dvd_bit};
    w_trial      = {1'b0, w_shift} - {2'b00, dsr};
    q_bit        = ~w_trial[data_width+1];
    prem_next    = q_bit ? w_trial[data_width:0] : w_shift;
  end

endmodule

// File: rtl/alu_div_seq.sv
// Iterative restoring divider with start/busy/done handshake and one-cycle sign fix-up.
// Optional: ALU_DIV_ZERO_FAST_EN skips the iteration phase when the divisor is zero.
module alu_div_seq
  import alu_div_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_op,
  input  logic [data_width-1:0] dividend,
  input  logic [data_width-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [data_width-1:0] quotient,
  output logic [data_width-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CW = $clog2(data_width);
  localparam logic [CW-1:0] LAST_STEP = CW'(data_width - 1);

  state_t                r_state, w_state_next;
  logic                  r_signed;
  logic                  r_dvd_neg;
  logic                  r_dsr_neg;
  logic                  r_dsr_zero;
  logic [data_width-1:0] r_dvd_raw;
  logic [data_width-1:0] r_dvd;
  logic [data_width-1:0] r_dsr_mag;
  logic [data_width:0]   r_prem;
  logic [CW-1:0]         r_cnt;

  logic [data_width-1:0] w_dvd_mag;
  logic [data_width-1:0] w_dsr_mag;
  logic [data_width:0]   w_prem_next;
  logic                  w_q_bit;
  logic [data_width-1:0] w_quo_fix;
  logic [data_width-1:0] w_rem_fix;

  div_step #(
    .data_width(data_width)
  ) u_step (
    .prem      (r_prem),
    .dvd_bit   (r_dvd[data_width-1]),
    .dsr       (r_dsr_mag),
    .prem_next (w_prem_next),
    .q_bit     (w_q_bit)
  );

  always_comb begin
    w_dvd_mag = (signed_op && dividend[data_width-1]) ? -dividend : dividend;
    w_dsr_mag = (signed_op && divisor[data_width-1])  ? -divisor  : divisor;
    w_quo_fix = (r_signed && (r_dvd_neg ^ r_dsr_neg)) ? -r_dvd : r_dvd;
    w_rem_fix = (r_signed && r_dvd_neg) ? -r_prem[data_width-1:0]
                                        : r_prem[data_width-1:0];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
`ifdef ALU_DIV_ZERO_FAST_EN
          w_state_next = (divisor == '0) ? FIX : CALC;
`else
          w_state_next = CALC;
`endif
        end
      end
      CALC:    if (r_cnt == LAST_STEP) w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_signed    <= 1'b0;
      r_dvd_neg   <= 1'b0;
      r_dsr_neg   <= 1'b0;
      r_dsr_zero  <= 1'b0;
      r_dvd_raw   <= '0;
      r_dvd       <= '0;
      r_dsr_mag   <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_signed    <= signed_op;
            r_dvd_neg   <= signed_op & dividend[data_width-1];
            r_dsr_neg   <= signed_op & divisor[data_width-1];
            r_dsr_zero  <= (divisor == '0);
            r_dvd_raw   <= dividend;
            r_dvd       <= w_dvd_mag;
            r_dsr_mag   <= w_dsr_mag;
            r_prem      <= '0;
            r_cnt       <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          // r_dvd shifts dividend bits out the top and quotient bits in at the bottom
          r_prem <= w_prem_next;
          r_dvd  <= {r_dvd[data_width-2:0], w_q_bit};
          r_cnt  <= r_cnt + 1'b1;
        end
        FIX: begin
          if (r_dsr_zero) begin
            quotient    <= '1;
            remainder   <= r_dvd_raw;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= w_quo_fix;
            remainder   <= w_rem_fix;
          end
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed self-checking bench for alu_div_seq at the default 32-bit width.
module tb_alu_div_seq;
  import alu_div_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int          edges;
  int          bcyc;
  int          done_seen;

`ifdef ALU_DIV_ZERO_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  alu_div_seq #(
    .data_width(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Call between edges: presents operands, lets the next edge capture them.
  task automatic drive_start(input logic sg, input logic [31:0] a, input logic [31:0] b);
    start     = 1'b1;
    signed_op = sg;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = 32'hDEAD_BEEF;
    divisor   = 32'h0BAD_F00D;
  endtask

  task automatic launch(input logic sg, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive_start(sg, a, b);
  endtask

  task automatic wait_done(output int n_edges, output int n_busy);
    n_edges = 0;
    n_busy  = busy ? 1 : 0;
    while (n_edges < 100) begin
      @(posedge clk);
      #1;
      n_edges++;
      if (done) break;
      if (busy) n_busy++;
    end
  endtask

  task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input int lat);
    int e;
    int bc;
    launch(sg, a, b);
    wait_done(e, bc);
    check_eq({tag, ".lat"}, e, lat);
    check_eq({tag, ".busy_cycles"}, bc, lat);
    check_eq({tag, ".q"}, quotient, eq);
    check_eq({tag, ".r"}, remainder, er);
    check_eq({tag, ".dz"}, div_by_zero, edz);
    @(posedge clk);
    #1;
    check_eq({tag, ".done_pulse"}, done, 1'b0);
    check_eq({tag, ".hold_q"}, quotient, eq);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1;
    check_eq("rst.busy", busy, 1'b0);
    check_eq("rst.done", done, 1'b0);
    check_eq("rst.q", quotient, 32'h0);
    check_eq("rst.r", remainder, 32'h0);
    check_eq("rst.dz", div_by_zero, 1'b0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    run_op("udiv_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    run_op("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("sdiv_7_m2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 33);
    run_op("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 33);
    run_op("udiv_full", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33);
    run_op("udiv_zero", 1'b0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, DZ_LAT);
    run_op("sdiv_zero", 1'b1, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, DZ_LAT);

    // next accepted start clears the divide-by-zero flag
    launch(1'b0, 32'd50, 32'd5);
    check_eq("dz_clear.flag", div_by_zero, 1'b0);
    check_eq("dz_clear.busy", busy, 1'b1);
    wait_done(edges, bcyc);
    check_eq("dz_clear.q", quotient, 32'd10);

    // start pulsed mid-CALC must not disturb the in-flight operands
    launch(1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    drive_start(1'b1, 32'd5, 32'd1);
    wait_done(edges, bcyc);
    check_eq("ignore.lat", edges + 6, 33);
    check_eq("ignore.q", quotient, 32'd14);
    check_eq("ignore.r", remainder, 32'd2);

    // start presented in the done cycle is accepted on the following edge
    check_eq("b2b.done_now", done, 1'b1);
    drive_start(1'b0, 32'd81, 32'd9);
    check_eq("b2b.busy", busy, 1'b1);
    check_eq("b2b.done_drop", done, 1'b0);
    wait_done(edges, bcyc);
    check_eq("b2b.lat", edges, 33);
    check_eq("b2b.q", quotient, 32'd9);
    check_eq("b2b.r", remainder, 32'd0);

    // asynchronous reset at iteration 10, asserted between edges
    launch(1'b1, 32'hFFFF_FC18, 32'd3);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst.busy", busy, 1'b0);
    check_eq("arst.done", done, 1'b0);
    check_eq("arst.q", quotient, 32'h0);
    check_eq("arst.r", remainder, 32'h0);
    check_eq("arst.dz", div_by_zero, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check_eq("arst.no_done", done_seen, 0);
    run_op("after_rst", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
